gam_edge_age_ctrl: RTL and testbench
====================================

GAM_EDGE_AGE_CTRL -- requirements
Module: gam_edge_age_ctrl

Interface
REQ-001 Parameter NODE_COUNT, default 50, nodes per class; valid node indices are 1..NODE_COUNT.
REQ-002 Parameter CLASS_COUNT, default 5, classes; valid class indices are 1..CLASS_COUNT.
REQ-003 Parameter AGE_MAX, default 6, oldest surviving edge age.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 class_id  in  3  target class.
REQ-008 n1  in  6  winner node index.
REQ-009 n2  in  6  second-winner node index.
REQ-010 busy  out  1  high from the cycle after an accepted start through the DONE cycle.
REQ-011 done  out  1  one-cycle pulse on completion.
REQ-012 err  out  1  one-cycle pulse on a rejected request.
REQ-013 prune_cnt  out  6  edges removed by the last completed run; held until the next accepted start.
REQ-014 mem_en  out  1  connection-memory access strobe.
REQ-015 mem_we  out  1  1 = write, 0 = read.
REQ-016 mem_class, mem_row, mem_col  out  3/6/6  connection address [class][row][col].
REQ-017 mem_wpres, mem_wage  out  1/32  write data: connection_presence and age.
REQ-018 mem_rpres, mem_rage  in  1/32  read data, valid exactly one cycle after a read strobe.

Function
REQ-019 FSM states: IDLE, RD, WAIT, WR_FWD, WR_REV, NEXT, LINK_FWD, LINK_REV, DONE.
REQ-020 The block rejects start in IDLE when class_id is not in 1..CLASS_COUNT, n1 or n2 is not in 1..NODE_COUNT, or n1==n2: err pulses the next cycle, there is no memory access, and the FSM stays in IDLE.
REQ-021 A valid start latches class_id/n1/n2, clears prune_cnt, sets scan index j=1 and goes to RD; start while busy is ignored.
REQ-022 j==n1 skips directly to NEXT.
REQ-023 RD issues a read of [c][n1][j]; WAIT captures the read data.
REQ-024 If the captured presence is 0, the FSM goes WAIT->NEXT with no write.
REQ-025 If presence is 1, new age = read age + 1; if new age > AGE_MAX, write presence=0, age=0, and increment prune_cnt unless j==n2; otherwise write presence=1, age=new age.
REQ-026 WR_FWD writes [c][n1][j]; WR_REV writes the identical value to [c][j][n1], keeping the matrix symmetric.
REQ-027 NEXT increments j; after j==NODE_COUNT it goes to LINK_FWD, otherwise to RD.
REQ-028 LINK_FWD writes [c][n1][n2] with presence=1, age=0; LINK_REV writes [c][n2][n1] the same; then DONE.
REQ-029 DONE pulses done and returns to IDLE; busy deasserts in the following cycle.
REQ-030 mem_en is high only in RD, WR_FWD, WR_REV, LINK_FWD and LINK_REV; at most one access per cycle.
REQ-031 Cycle count per run: 2 for j==n1 (skip + NEXT), 3 per absent edge, 5 per present edge, plus 3 for LINK/DONE.
REQ-032 The age adder is 32-bit, unsigned compare; a read age of 32'hFFFFFFFF is treated as prune, never wrapped.

Reset
REQ-033 rst forces IDLE; busy, done, err, mem_en and mem_we become 0, and prune_cnt, mem_* addresses and write data become 0.
REQ-034 rst mid-run aborts next cycle; already-written entries are not restored and no done is issued.

Structure
REQ-035 NODE_COUNT, CLASS_COUNT, AGE_MAX, the index widths and single_node_connection_T come from the shared GAM package; the FSM state enum is added there.
REQ-036 The block is a single module with no sub-modules; the connection memory is external.

Verification
REQ-037 Empty class 2, n1=3, n2=7 -> only reads plus 2 link writes; [2][3][7]=[2][7][3]=(1,0); prune_cnt=0; done at cycle 3*49+2+3.
REQ-038 Edge [1][4][9] age 2, n1=4, n2=5 -> [1][4][9] and [1][9][4] both equal (1,3); link 4-5 created.
REQ-039 Edge [1][4][9] age 6 (AGE_MAX), n1=4 -> both directions (0,0); prune_cnt=1.
REQ-040 Existing edge 4-5 age 6, n1=4, n2=5 -> edge ends (1,0); prune_cnt=0.
REQ-041 start with n1=n2=3, class_id=0, or n1=51 -> err pulse, mem_en never high, busy stays 0.
REQ-042 rst asserted mid-scan, then a fresh valid start -> IDLE next cycle, no done for the aborted run, second run completes normally.

Source files
------------

// File: rtl/gam_edge_age_ctrl_pkg.sv
// rtl/gam_edge_age_ctrl_pkg.sv - shared GAM constants, connection type and edge-age FSM states
package gam_edge_age_ctrl_pkg;

  localparam int GAM_NODE_COUNT  = 50;
  localparam int GAM_CLASS_COUNT = 5;
  localparam int GAM_AGE_MAX     = 6;
  localparam int CLASS_W         = 3;
  localparam int NODE_W          = 6;
  localparam int AGE_W           = 32;

  typedef struct packed {
    logic             presence;
    logic [AGE_W-1:0] age;
  } single_node_connection_T;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR_FWD,
    ST_WR_REV,
    ST_NEXT,
    ST_LINK_FWD,
    ST_LINK_REV,
    ST_DONE
  } state_t;

  // Widened add so an all-ones age counts as expired instead of wrapping to zero.
  function automatic logic is_aged_out(input logic [AGE_W-1:0] age,
                                       input logic [AGE_W-1:0] limit);
    return ({1'b0, age} + {{AGE_W{1'b0}}, 1'b1}) > {1'b0, limit};
  endfunction

endpackage

// File: rtl/gam_edge_age_ctrl_if.sv
// rtl/gam_edge_age_ctrl_if.sv - connection-memory port between the edge-age controller and its external matrix
interface gam_edge_age_ctrl_if;
  import gam_edge_age_ctrl_pkg::*;

  logic               mem_en;
  logic               mem_we;
  logic [CLASS_W-1:0] mem_class;
  logic [NODE_W-1:0]  mem_row;
  logic [NODE_W-1:0]  mem_col;
  logic               mem_wpres;
  logic [AGE_W-1:0]   mem_wage;
  logic               mem_rpres;
  logic [AGE_W-1:0]   mem_rage;

  modport master (
    output mem_en, mem_we, mem_class, mem_row, mem_col, mem_wpres, mem_wage,
    input  mem_rpres, mem_rage
  );

  modport slave (
    input  mem_en, mem_we, mem_class, mem_row, mem_col, mem_wpres, mem_wage,
    output mem_rpres, mem_rage
  );

endinterface

// File: rtl/gam_edge_age_ctrl.sv
// rtl/gam_edge_age_ctrl.sv - ages every edge of winner n1, prunes expired ones, then links n1<->n2
module gam_edge_age_ctrl
  import gam_edge_age_ctrl_pkg::*;
#(
  parameter int NODE_COUNT  = GAM_NODE_COUNT,
  parameter int CLASS_COUNT = GAM_CLASS_COUNT,
  parameter int AGE_MAX     = GAM_AGE_MAX
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [CLASS_W-1:0] i_class_id,
  input  logic [NODE_W-1:0]  i_n1,
  input  logic [NODE_W-1:0]  i_n2,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [NODE_W-1:0]  o_prune_cnt,
  gam_edge_age_ctrl_if.master mem
);

  localparam logic [NODE_W-1:0]  NODE_LAST  = NODE_W'(NODE_COUNT);
  localparam logic [CLASS_W-1:0] CLASS_LAST = CLASS_W'(CLASS_COUNT);
  localparam logic [AGE_W-1:0]   AGE_LIMIT  = AGE_W'(AGE_MAX);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CLASS_W-1:0]      r_class;
  logic [NODE_W-1:0]       r_n1;
  logic [NODE_W-1:0]       r_n2;
  logic [NODE_W-1:0]       r_j;
  logic [NODE_W-1:0]       r_prune_cnt;
  single_node_connection_T r_wdata;
  logic                    r_err;
  logic                    w_req_ok;
  logic                    w_aged_out;
  logic [AGE_W-1:0]        w_age_inc;

  assign w_req_ok = (i_class_id != '0) && (i_class_id <= CLASS_LAST) &&
                    (i_n1 != '0) && (i_n1 <= NODE_LAST) &&
                    (i_n2 != '0) && (i_n2 <= NODE_LAST) &&
                    (i_n1 != i_n2);

  assign w_aged_out = is_aged_out(mem.mem_rage, AGE_LIMIT);
  assign w_age_inc  = mem.mem_rage + AGE_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_class     <= '0;
      r_n1        <= '0;
      r_n2        <= '0;
      r_j         <= '0;
      r_prune_cnt <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_req_ok) begin
              r_class     <= i_class_id;
              r_n1        <= i_n1;
              r_n2        <= i_n2;
              r_j         <= NODE_W'(1);
              r_prune_cnt <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          r_wdata.presence <= ~w_aged_out;
          r_wdata.age      <= w_aged_out ? '0 : w_age_inc;
          // The n1-n2 edge is relinked right afterwards, so it never counts as pruned.
          if (mem.mem_rpres && w_aged_out && (r_j != r_n2))
            r_prune_cnt <= r_prune_cnt + NODE_W'(1);
        end
        ST_NEXT: r_j <= r_j + NODE_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state  = r_state;
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_class = '0;
    mem.mem_row   = '0;
    mem.mem_col   = '0;
    mem.mem_wpres = 1'b0;
    mem.mem_wage  = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && w_req_ok) w_next_state = ST_RD;
      end
      ST_RD: begin
        if (r_j == r_n1) begin
          w_next_state = ST_NEXT;
        end else begin
          mem.mem_en    = 1'b1;
          mem.mem_class = r_class;
          mem.mem_row   = r_n1;
          mem.mem_col   = r_j;
          w_next_state  = ST_WAIT;
        end
      end
      ST_WAIT: w_next_state = mem.mem_rpres ? ST_WR_FWD : ST_NEXT;
      ST_WR_FWD: begin
        mem.mem_en    = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_class = r_class;
        mem.mem_row   = r_n1;
        mem.mem_col   = r_j;
        mem.mem_wpres = r_wdata.presence;
        mem.mem_wage  = r_wdata.age;
        w_next_state  = ST_WR_REV;
      end
      ST_WR_REV: begin
        mem.mem_en    = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_class = r_class;
        mem.mem_row   = r_j;
        mem.mem_col   = r_n1;
        mem.mem_wpres = r_wdata.presence;
        mem.mem_wage  = r_wdata.age;
        w_next_state  = ST_NEXT;
      end
      ST_NEXT: w_next_state = (r_j == NODE_LAST) ? ST_LINK_FWD : ST_RD;
      ST_LINK_FWD: begin
        mem.mem_en    = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_class = r_class;
        mem.mem_row   = r_n1;
        mem.mem_col   = r_n2;
        mem.mem_wpres = 1'b1;
        w_next_state  = ST_LINK_REV;
      end
      ST_LINK_REV: begin
        mem.mem_en    = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_class = r_class;
        mem.mem_row   = r_n2;
        mem.mem_col   = r_n1;
        mem.mem_wpres = 1'b1;
        w_next_state  = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_err       = r_err;
  assign o_prune_cnt = r_prune_cnt;

endmodule

// File: tb/tb_gam_edge_age_ctrl.sv
// tb/tb_gam_edge_age_ctrl.sv - self-checking bench for gam_edge_age_ctrl with an external matrix model
module tb_gam_edge_age_ctrl;
  import gam_edge_age_ctrl_pkg::*;

  localparam int N  = GAM_NODE_COUNT;
  localparam int AM = GAM_AGE_MAX;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] class_id = '0;
  logic [5:0] n1 = '0;
  logic [5:0] n2 = '0;
  logic       busy, done, err;
  logic [5:0] prune_cnt;

  gam_edge_age_ctrl_if mif ();

  gam_edge_age_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_class_id(class_id),
    .i_n1(n1), .i_n2(n2), .o_busy(busy), .o_done(done), .o_err(err),
    .o_prune_cnt(prune_cnt), .mem(mif)
  );

  always #5 clk = ~clk;

  // Connection matrix (m_*) and model expectation (e_*)
  logic        m_pres [8][64][64];
  logic [31:0] m_age  [8][64][64];
  logic        e_pres [8][64][64];
  logic [31:0] e_age  [8][64][64];

  logic        bd_we = 1'b0, bd_clear = 1'b0, bd_pres = 1'b0;
  logic [2:0]  bd_c = '0;
  logic [5:0]  bd_r = '0, bd_col = '0;
  logic [31:0] bd_age = '0;

  always @(posedge clk) begin
    mif.mem_rpres <= 1'($urandom);
    mif.mem_rage  <= $urandom;
    if (mif.mem_en && !mif.mem_we) begin
      mif.mem_rpres <= m_pres[mif.mem_class][mif.mem_row][mif.mem_col];
      mif.mem_rage  <= m_age[mif.mem_class][mif.mem_row][mif.mem_col];
    end
    if (mif.mem_en && mif.mem_we) begin
      m_pres[mif.mem_class][mif.mem_row][mif.mem_col] = mif.mem_wpres;
      m_age[mif.mem_class][mif.mem_row][mif.mem_col]  = mif.mem_wage;
    end
    if (bd_clear) begin
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 64; r++)
          for (int k = 0; k < 64; k++) begin
            m_pres[c][r][k] = 1'b0;
            m_age[c][r][k]  = '0;
          end
    end else if (bd_we) begin
      m_pres[bd_c][bd_r][bd_col] = bd_pres;
      m_age[bd_c][bd_r][bd_col]  = bd_age;
    end
  end

  int done_cnt = 0, err_cnt = 0, en_cnt = 0, wr_cnt = 0, viol_cnt = 0;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (mif.mem_en === 1'b1) en_cnt++;
    if (mif.mem_en === 1'b1 && mif.mem_we === 1'b1) wr_cnt++;
    if (mif.mem_en === 1'b1 && busy !== 1'b1) viol_cnt++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic bd_write(input int c, input int r, input int k, input logic p, input logic [31:0] a);
    bd_c = 3'(c); bd_r = 6'(r); bd_col = 6'(k); bd_pres = p; bd_age = a; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_edge(input int c, input int a, input int b, input logic p, input logic [31:0] age);
    bd_write(c, a, b, p, age);
    bd_write(c, b, a, p, age);
  endtask

  task automatic clear_mem();
    bd_clear = 1'b1;
    @(negedge clk);
    bd_clear = 1'b0;
  endtask

  task automatic fill_random(input int c, input int dens);
    logic [31:0] a;
    for (int r = 1; r <= N; r++)
      for (int k = r + 1; k <= N; k++)
        if ($urandom_range(0, 99) < dens) begin
          a = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, AM + 1));
          bd_edge(c, r, k, ($urandom_range(0, 3) != 0), a);
        end
  endtask

  // Reference: walk every neighbour j of n1, age/prune present edges, then link n1-n2.
  task automatic model_run(input int c, input int a, input int b,
                           output int prune, output int cycles, output int writes);
    longint na;
    e_pres = m_pres;
    e_age  = m_age;
    prune = 0; cycles = 3; writes = 2;
    for (int j = 1; j <= N; j++) begin
      if (j == a) cycles += 2;
      else if (e_pres[c][a][j] == 1'b1) begin
        na = longint'(e_age[c][a][j]) + 1;
        cycles += 5; writes += 2;
        if (na > AM) begin
          e_pres[c][a][j] = 1'b0; e_age[c][a][j] = '0;
          e_pres[c][j][a] = 1'b0; e_age[c][j][a] = '0;
          if (j != b) prune++;
        end else begin
          e_pres[c][a][j] = 1'b1; e_age[c][a][j] = 32'(na);
          e_pres[c][j][a] = 1'b1; e_age[c][j][a] = 32'(na);
        end
      end else cycles += 3;
    end
    e_pres[c][a][b] = 1'b1; e_age[c][a][b] = '0;
    e_pres[c][b][a] = 1'b1; e_age[c][b][a] = '0;
  endtask

  task automatic check_matrix(input string name);
    int diffs, fc, fr, fk;
    diffs = 0; fc = 0; fr = 0; fk = 0;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 64; r++)
        for (int k = 0; k < 64; k++)
          if (m_pres[c][r][k] !== e_pres[c][r][k] || m_age[c][r][k] !== e_age[c][r][k]) begin
            if (diffs == 0) begin fc = c; fr = r; fk = k; end
            diffs++;
          end
    n_checks++;
    if (diffs != 0) begin
      n_fail++;
      $display("FAIL %s_matrix: %0d entries differ, first [%0d][%0d][%0d] got (%0b,%0d) want (%0b,%0d)",
               name, diffs, fc, fr, fk, m_pres[fc][fr][fk], m_age[fc][fr][fk],
               e_pres[fc][fr][fk], e_age[fc][fr][fk]);
    end
  endtask

  task automatic run_check(input int c, input int a, input int b, input string name,
                           input bit poke, output int obs_cyc);
    int ep, ecyc, ewr, wr0, d0, cyc;
    bit seen;
    model_run(c, a, b, ep, ecyc, ewr);
    wr0 = wr_cnt; d0 = done_cnt;
    @(negedge clk);
    class_id = 3'(c); n1 = 6'(a); n2 = 6'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; seen = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_rise: got %b want 1", name, busy); end
    while (!seen && cyc < 2000) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (poke && cyc == 20) begin start = 1'b1; class_id = 3'd1; n1 = 6'd1; n2 = 6'd2; end
        else start = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    obs_cyc = cyc;
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL %s_timeout: no done within %0d cycles", name, cyc);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end else if (cyc != ecyc) begin
      n_fail++; $display("FAIL %s_done_cycle: got %0d want %0d", name, cyc, ecyc);
    end
    if (poke) begin start = 1'b1; class_id = 3'd1; n1 = 6'd1; n2 = 6'd2; end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_fall: busy=%b done=%b want 0/0", name, busy, done);
    end
    n_checks++;
    if (prune_cnt !== 6'(ep)) begin
      n_fail++; $display("FAIL %s_prune_cnt: got %0d want %0d", name, prune_cnt, ep);
    end
    n_checks++;
    if (wr_cnt - wr0 != ewr || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s_writes_done: writes %0d want %0d, done pulses %0d want 1",
               name, wr_cnt - wr0, ewr, done_cnt - d0);
    end
    check_matrix(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, err, mif.mem_en, mif.mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, mif.mem_en, mif.mem_we});
    end
    n_checks++;
    if ({prune_cnt, mif.mem_class, mif.mem_row, mif.mem_col, mif.mem_wpres, mif.mem_wage} !== '0) begin
      n_fail++; $display("FAIL reset_data: prune=%0d class=%0d row=%0d col=%0d wp=%b wa=%0d want all 0",
                         prune_cnt, mif.mem_class, mif.mem_row, mif.mem_col, mif.mem_wpres, mif.mem_wage);
    end
    rst = 1'b0;
    clear_mem();
  endtask

  task automatic test_empty();
    int cyc;
    clear_mem();
    run_check(2, 3, 7, "empty", 1'b0, cyc);
    n_checks++;
    if (cyc != 152 || m_pres[2][3][7] !== 1'b1 || m_age[2][7][3] !== 32'd0 || m_pres[2][7][3] !== 1'b1) begin
      n_fail++; $display("FAIL empty_fixed: cycle %0d want 152, link (%b,%0d)/(%b,%0d) want (1,0)",
                         cyc, m_pres[2][3][7], m_age[2][3][7], m_pres[2][7][3], m_age[2][7][3]);
    end
  endtask

  task automatic test_directed();
    int cyc;
    clear_mem();
    bd_edge(1, 4, 9, 1'b1, 32'd2);
    run_check(1, 4, 5, "age_inc", 1'b0, cyc);
    n_checks++;
    if ({m_pres[1][4][9], m_age[1][4][9], m_pres[1][9][4], m_age[1][9][4]} !== {1'b1, 32'd3, 1'b1, 32'd3}) begin
      n_fail++; $display("FAIL age_inc_fixed: got (%b,%0d)/(%b,%0d) want (1,3)/(1,3)",
                         m_pres[1][4][9], m_age[1][4][9], m_pres[1][9][4], m_age[1][9][4]);
    end
    clear_mem();
    bd_edge(1, 4, 9, 1'b1, 32'(AM));
    run_check(1, 4, 5, "prune", 1'b0, cyc);
    n_checks++;
    if ({m_pres[1][4][9], m_age[1][4][9], m_pres[1][9][4], m_age[1][9][4]} !== '0 || prune_cnt !== 6'd1) begin
      n_fail++; $display("FAIL prune_fixed: got (%b,%0d)/(%b,%0d) prune %0d want (0,0)/(0,0) prune 1",
                         m_pres[1][4][9], m_age[1][4][9], m_pres[1][9][4], m_age[1][9][4], prune_cnt);
    end
    clear_mem();
    bd_edge(1, 4, 5, 1'b1, 32'(AM));
    run_check(1, 4, 5, "relink", 1'b0, cyc);
    n_checks++;
    if ({m_pres[1][4][5], m_age[1][4][5]} !== {1'b1, 32'd0} || prune_cnt !== 6'd0) begin
      n_fail++; $display("FAIL relink_fixed: got (%b,%0d) prune %0d want (1,0) prune 0",
                         m_pres[1][4][5], m_age[1][4][5], prune_cnt);
    end
    clear_mem();
    bd_edge(4, 2, 30, 1'b1, 32'hFFFF_FFFF);
    bd_edge(4, 2, 31, 1'b1, 32'd5);
    run_check(4, 2, 40, "wrap", 1'b0, cyc);
    n_checks++;
    if (m_pres[4][2][30] !== 1'b0 || m_age[4][30][2] !== 32'd0 || m_age[4][2][31] !== 32'd6 || prune_cnt !== 6'd1) begin
      n_fail++; $display("FAIL wrap_fixed: got p30=%b a30=%0d a31=%0d prune %0d want 0,0,6,1",
                         m_pres[4][2][30], m_age[4][30][2], m_age[4][2][31], prune_cnt);
    end
    fill_random(5, 40);
    run_check(5, N, 1, "boundary", 1'b0, cyc);
  endtask

  task automatic test_reject();
    int tc[4] = '{3, 0, 1, 6};
    int ta[4] = '{3, 3, 51, 1};
    int tb[4] = '{3, 7, 3, 2};
    int e0, en0;
    e0 = err_cnt; en0 = en_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      class_id = 3'(tc[k]); n1 = 6'(ta[k]); n2 = 6'(tb[k]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reject%0d_err: err=%b busy=%b want 1/0", k, err, busy);
      end
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reject%0d_pulse: err=%b busy=%b want 0/0", k, err, busy);
      end
    end
    n_checks++;
    if (en_cnt != en0 || err_cnt - e0 != 4) begin
      n_fail++; $display("FAIL reject_totals: mem_en cycles %0d want 0, err pulses %0d want 4",
                         en_cnt - en0, err_cnt - e0);
    end
  endtask

  task automatic test_abort();
    int d0, cyc;
    fill_random(3, 40);
    bd_edge(3, 10, 11, 1'b1, 32'd6);
    d0 = done_cnt;
    @(negedge clk);
    class_id = 3'd3; n1 = 6'd10; n2 = 6'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || mif.mem_en !== 1'b0 || prune_cnt !== 6'd0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b mem_en=%b prune=%0d want 0/0/0", busy, mif.mem_en, prune_cnt);
    end
    repeat (300) @(negedge clk);
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++; $display("FAIL abort_no_done: done pulses %0d want 0", done_cnt - d0);
    end
    run_check(3, 10, 20, "abort_rerun", 1'b0, cyc);
  endtask

  task automatic test_random();
    int c, a, b, cyc;
    for (int it = 0; it < 5; it++) begin
      c = $urandom_range(1, 5);
      a = $urandom_range(1, N);
      b = $urandom_range(1, N - 1);
      if (b >= a) b++;
      fill_random(c, $urandom_range(10, 50));
      run_check(c, a, b, $sformatf("random%0d", it), 1'b0, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fill_random(1, 30);
    run_check(1, 7, 8, "b2b_first", 1'b1, cyc);
    run_check(1, 8, 7, "b2b_second", 1'b0, cyc);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_directed();
    test_reject();
    test_abort();
    test_random();
    test_back_to_back();
    n_checks++;
    if (viol_cnt != 0) begin
      n_fail++; $display("FAIL mem_en_idle: %0d strobes while not busy, want 0", viol_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
